// File: rtl/counter_scheduler_if.sv
// counter_scheduler_if: requester and counter signals shared with counter_scheduler
interface counter_scheduler_if #(parameter int W = 4);
  logic [1:0] req;
  logic [W-1:0] start0, start1, limit0, limit1;
  logic [1:0] gnt, done;
  logic busy;
  logic cnt_en, cnt_load;
  logic [W-1:0] cnt_b, cnt_l, cnt_d;
  logic cnt_tc;
  modport master (
    output req, start0, start1, limit0, limit1, cnt_d, cnt_tc,
    input  gnt, done, busy, cnt_en, cnt_load, cnt_b, cnt_l
  );
  modport slave (
    input  req, start0, start1, limit0, limit1, cnt_d, cnt_tc,
    output gnt, done, busy, cnt_en, cnt_load, cnt_b, cnt_l
  );
endinterface

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin sharing of one four_bit_counter between two requesters
module counter_scheduler #(parameter int W = 4) (
  input logic clk,
  input logic rst,
  counter_scheduler_if.slave sif
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, nxt;
  logic last, sel, win, own;
  logic [W-1:0] start_q, limit_q;
  assign win = (&sif.req) ? ~last : sif.req[1];
  assign own = sif.req[sel];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      sel <= 1'b0;
      start_q <= '0;
      limit_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && |sif.req) begin
        sel <= win;
        start_q <= win ? sif.start1 : sif.start0;
        limit_q <= win ? sif.limit1 : sif.limit0;
      end
      if (state != IDLE && (state == DONE || !own)) last <= sel;
    end
  end
  always_comb begin
    nxt = state == IDLE ? (|sif.req ? LOAD : IDLE) :
          state == DONE ? IDLE :
          !own          ? IDLE :
          state == LOAD ? RUN :
          sif.cnt_tc    ? DONE : RUN;
  end
  assign sif.busy = state != IDLE;
  assign sif.gnt = sif.busy ? {sel, ~sel} : 2'b00;
  assign sif.done = state == DONE ? {sel, ~sel} : 2'b00;
  assign sif.cnt_load = state == LOAD;
  assign sif.cnt_en = state == RUN && !sif.cnt_tc;
  assign sif.cnt_b = state == LOAD ? start_q : '0;
  assign sif.cnt_l = sif.busy ? limit_q : '0;
endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Sequencing controller that shares one `four_bit_counter` instance between two requesters. Each requester asks for a counting run from its own start value to its own limit. The scheduler arbitrates round-robin, loads the counter, enables it until terminal count, and returns a one-cycle done pulse to the winner. It sits between requester logic and the counter and is the only driver of the counter's `en`, `load`, `b` and `l` inputs.

## Interface
- `W`, default 4: counter data width; fixed at 4 for `four_bit_counter`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset; also drives the counter's `rst`.
- `req`  in  2  per-requester run request; level, held until `done` for that requester.
- `start0`, `start1`  in  W  start (load) value for requester 0 / 1.
- `limit0`, `limit1`  in  W  terminal-count value for requester 0 / 1.
- `gnt`  out  2  one-hot; high for the owning requester from LOAD through DONE.
- `done`  out  2  one-cycle pulse to the owner when its run completes normally.
- `busy`  out  1  high whenever state != IDLE.
- `cnt_en`  out  1  to counter `en`.
- `cnt_load`  out  1  to counter `load`.
- `cnt_b`  out  W  to counter `b`.
- `cnt_l`  out  W  to counter `l`.
- `cnt_d`  in  W  counter value `d`.
- `cnt_tc`  in  1  counter `tc`: high while `cnt_d == cnt_l`.

## Operation
- Counter contract:
  - Synchronous `load` takes priority over `en` and sets `d = b`.
  - `en` increments `d` modulo 2^W.
  - `tc` is combinational, `d == l`.
- Reset state:
  - State IDLE.
  - Last-served pointer = 1, so requester 0 wins the first tie.
  - Captured start/limit = 0; `sel` = 0.
  - All outputs 0: `gnt`, `done`, `busy`, `cnt_en`, `cnt_load`, `cnt_b`, `cnt_l`.
- States:
  - IDLE: if any `req` is high, choose a winner and go to LOAD.
    - One request high: that requester wins.
    - Both high: the requester that is not the last-served wins.
    - On this edge, capture the winner's `start`/`limit` into internal registers and record `sel`.
  - LOAD: `cnt_load`=1, `cnt_en`=0, `cnt_b`=captured start. Always goes to RUN after one cycle.
  - RUN: `cnt_en` = !`cnt_tc`, combinational, so the counter stops at the limit.
    - While `cnt_tc`=1: go to DONE.
  - DONE: `done[sel]`=1 for one cycle, then IDLE. Last-served pointer is updated to `sel` on this edge.
- `cnt_l` = captured limit in all states except IDLE, where it is 0. `cnt_b` = captured start in LOAD only, else 0.
- `gnt[sel]`=1 in LOAD, RUN and DONE.
- Abort: if `req[sel]` is low in LOAD or RUN, go to IDLE on the next edge.
  - No `done` pulse; `cnt_en` drops.
  - Last-served pointer updates to `sel`.
  - The counter keeps its value.
- Changes to `start`/`limit` after capture have no effect on the current run.
- Requests from the non-owner during a run are held pending and arbitrated in IDLE.
- Wrap-around:
  - start > limit: the counter wraps through 2^W-1 → 0.
  - start == limit: zero increments.
- A requester whose `req` is still high in the IDLE cycle after its `done` starts a new run, unless the other requester wins round-robin.

## Timing
- N = (limit − start) mod 2^W increments per run.
- Sequence from the edge at which `req[i]` is accepted in IDLE:
  - 1 cycle in LOAD.
  - N+1 cycles in RUN; the last RUN cycle has `cnt_tc`=1 and `cnt_en`=0.
  - `done[i]` is high in the cycle beginning N+2 edges after acceptance.
- At least one IDLE cycle separates consecutive runs. Back-to-back period = N+4 cycles.
- `gnt` rises one edge after acceptance and falls with `done`.
- `rst` asserted in any state: IDLE on that edge, all outputs 0 in the next cycle, no `done`. Counter `d` also resets to 0.
- `rst` overrides both request acceptance and abort on the same edge.

## Test plan
- Single run: reset, `req0`=1, start0=10, limit0=13.
  - `gnt`=01 for 6 cycles.
  - `cnt_load` for 1 cycle.
  - `cnt_d` goes 10, 11, 12, 13 and holds at 13.
  - `done0` pulses 5 edges after acceptance; `done1` never.
- Tie and rotation: `req`=11 held, both start=0, limit=2.
  - Runs are served 0, 1, 0, 1.
  - Each `done` is 4 edges after its acceptance edge, and runs are 6 cycles apart.
- Boundaries:
  - start=limit=7: RUN lasts 1 cycle, `cnt_en` never high, `done` 2 edges after acceptance.
  - start=14, limit=1: `cnt_d` goes 14, 15, 0, 1, N=3.
- Abort: `req0` dropped in the second RUN cycle.
  - IDLE next edge; `cnt_en`=0; no `done0`.
  - A pending `req1` is accepted in the following IDLE cycle.
- Reset mid-run: `rst`=1 during RUN.
  - Next cycle: all outputs 0, `busy`=0.
  - After release, `req0`/`req1` tie goes to requester 0.
